// File: rtl/mux_scan_reg_pkg.sv
//------------------------------------------------------------------------------
// Module  : mux_scan_reg_pkg
// Brief   : Shared state encoding and width helpers for the scanning mux.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mux_scan_reg_pkg;

    // Scan state flag: DIRECT while idle or in direct mode, SCAN while sweeping.
    typedef enum logic {
        ST_DIRECT = 1'b0,
        ST_SCAN   = 1'b1
    } state_t;

    // Ceiling log2 usable in constant expressions; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Channel-index width; never narrower than one bit.
    function automatic int sel_width(input int n_ch);
        return (clog2(n_ch) < 1) ? 1 : clog2(n_ch);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux_scan_reg_scan_counter.sv
//------------------------------------------------------------------------------
// Module  : scan_counter
// Brief   : Scan pointer and dwell counter for the round-robin scan.
//           ptr/last_dwell/wrap_next describe the current (effective) step;
//           restart makes the step behave as a fresh start at channel 0.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module scan_counter
    import mux_scan_reg_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int DWELL = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        step,
    input  logic                        restart,
    output logic [sel_width(N_CH)-1:0]  ptr,
    output logic                        last_dwell,
    output logic                        wrap_next
);

    localparam int SEL_W = sel_width(N_CH);
    localparam int DWL_W = clog2(DWELL) + 1;

    localparam logic [SEL_W-1:0] c_last_ch  = SEL_W'(N_CH - 1);
    localparam logic [DWL_W-1:0] c_last_dwl = DWL_W'(DWELL - 1);

    logic [SEL_W-1:0] r_cur;
    logic [DWL_W-1:0] r_dwl;
    logic [DWL_W-1:0] w_dwl;

    // Effective position: a restart reads as channel 0 with a fresh dwell.
    assign ptr        = restart ? '0 : r_cur;
    assign w_dwl      = restart ? '0 : r_dwl;
    assign last_dwell = (w_dwl == c_last_dwl);
    assign wrap_next  = last_dwell && (ptr == c_last_ch);

    // Advance on a scan step; a restart without a step clears the position.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur <= '0;
            r_dwl <= '0;
        end else if (step) begin
            if (last_dwell) begin
                r_dwl <= '0;
                r_cur <= wrap_next ? '0 : ptr + 1'b1;
            end else begin
                r_dwl <= w_dwl + 1'b1;
                r_cur <= ptr;
            end
        end else if (restart) begin
            r_cur <= '0;
            r_dwl <= '0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux_scan_reg.sv
//------------------------------------------------------------------------------
// Module  : mux_scan_reg
// Brief   : N_CH-channel registered multiplexer with direct select and an
//           autonomous round-robin scan with programmable dwell.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mux_scan_reg
    import mux_scan_reg_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 1,
    parameter int DWELL = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        mode,
    input  logic [sel_width(N_CH)-1:0]  sel,
    input  logic [N_CH*WIDTH-1:0]       din,
    output logic [WIDTH-1:0]            y,
    output logic [sel_width(N_CH)-1:0]  ch,
    output logic                        valid,
    output logic                        wrap
);

    localparam int SEL_W = sel_width(N_CH);

    state_t           r_state;
    logic [WIDTH-1:0] r_y;
    logic [SEL_W-1:0] r_ch;
    logic             r_valid;
    logic             r_wrap;

    logic             w_step;
    logic             w_restart;
    logic [SEL_W-1:0] w_ptr;
    logic             w_last_dwell;
    logic             w_wrap_next;
    logic [SEL_W-1:0] w_idx;
    logic             w_legal;
    logic [WIDTH-1:0] w_data;

    // A scan step happens on every enabled scan edge. Any enabled edge that is
    // not continuing an active scan (direct mode, or first scan edge) restarts.
    assign w_step    = en && mode;
    assign w_restart = en && (!mode || (r_state == ST_DIRECT));

    scan_counter #(
        .N_CH  (N_CH),
        .DWELL (DWELL)
    ) u_scan_counter (
        .clk        (clk),
        .rst        (rst),
        .step       (w_step),
        .restart    (w_restart),
        .ptr        (w_ptr),
        .last_dwell (w_last_dwell),
        .wrap_next  (w_wrap_next)
    );

    // Channel mux; indices past N_CH (non-power-of-two N_CH) read as zero.
    assign w_idx   = mode ? w_ptr : sel;
    assign w_legal = (int'(w_idx) < N_CH);
    assign w_data  = w_legal ? din[int'(w_idx)*WIDTH +: WIDTH] : '0;

    // Output and state registers; en=0 holds data and drops the strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_DIRECT;
            r_y     <= '0;
            r_ch    <= '0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
        end else if (!en) begin
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
        end else if (!mode) begin
            r_state <= ST_DIRECT;
            r_y     <= w_data;
            r_ch    <= sel;
            r_valid <= w_legal;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= ST_SCAN;
            r_y     <= w_data;
            r_ch    <= w_ptr;
            r_valid <= 1'b1;
            // wrap_next already implies the final dwell cycle; both are kept
            // so the strobe reads as "last dwell of the last channel".
            r_wrap  <= w_last_dwell && w_wrap_next;
        end
    end

    assign y     = r_y;
    assign ch    = r_ch;
    assign valid = r_valid;
    assign wrap  = r_wrap;

endmodule

`default_nettype wire
